// File: rtl/iic_cmd_arb.sv
// iic_cmd_arb: round-robin transaction arbiter sharing one byte-oriented IIC
// master command port between NREQ requesters (e.g. MS72xx init and runtime
// HDMI status polling). One register transaction is granted at a time. The
// winning command is latched and the completion is routed back. A watchdog
// aborts any transaction that the master never completes.
//
// Ports
//   clk, rst          : clock, synchronous active-high reset
//   en                : arbitration enable (no new grants while low)
//   req/req_rnw       : per-requester request and read(1)/write(0) select
//   req_dev/reg/wdata : per-requester command bytes, slice i = [8i+7:8i]
//   gnt               : one-hot grant, held for the whole transaction
//   rsp_valid         : one-hot one-cycle completion pulse
//   rsp_rdata/nack/timeout : completion payload, valid with rsp_valid
//   m_valid/m_ready   : command handshake towards the IIC master
//   m_rnw/dev/reg/wdata : latched command
//   m_done/m_rdata/m_nack : completion from the master
//   m_abort           : one-cycle pulse telling the master to drop the transfer
module iic_cmd_arb #(
  parameter int unsigned NREQ    = 2,
  parameter int unsigned TIMEOUT = 200_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   req_rnw,
  input  logic [8*NREQ-1:0] req_dev,
  input  logic [8*NREQ-1:0] req_reg,
  input  logic [8*NREQ-1:0] req_wdata,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [7:0]        rsp_rdata,
  output logic              rsp_nack,
  output logic              rsp_timeout,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_rnw,
  output logic [7:0]        m_dev,
  output logic [7:0]        m_reg,
  output logic [7:0]        m_wdata,
  input  logic              m_done,
  input  logic [7:0]        m_rdata,
  input  logic              m_nack,
  output logic              m_abort
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t             state_q, state_d;
  logic [IW-1:0]      ptr_q, ptr_d;
  logic [IW-1:0]      win_q, win_d;
  logic [NREQ-1:0]    gnt_q, gnt_d;
  logic [NREQ-1:0]    rsp_valid_q, rsp_valid_d;
  logic [7:0]         rsp_rdata_q, rsp_rdata_d;
  logic               rsp_nack_q, rsp_nack_d;
  logic               rsp_timeout_q, rsp_timeout_d;
  logic               m_valid_q, m_valid_d;
  logic               m_rnw_q, m_rnw_d;
  logic [7:0]         m_dev_q, m_dev_d;
  logic [7:0]         m_reg_q, m_reg_d;
  logic [7:0]         m_wdata_q, m_wdata_d;
  logic               m_abort_q, m_abort_d;
  logic [CW-1:0]      cnt_q, cnt_d;

  // Round-robin pick: first set request at or after ptr, wrapping.
  logic               found;
  logic [IW-1:0]      pick;
  logic               sel_rnw;
  logic [7:0]         sel_dev, sel_reg, sel_wdata;

  always_comb begin
    logic [IW-1:0] idx;
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = IW'((32'(ptr_q) + i) % NREQ);
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  always_comb begin
    sel_rnw   = 1'b0;
    sel_dev   = '0;
    sel_reg   = '0;
    sel_wdata = '0;
    for (int unsigned j = 0; j < NREQ; j++) begin
      if (pick == IW'(j)) begin
        sel_rnw   = req_rnw[j];
        sel_dev   = req_dev[8*j +: 8];
        sel_reg   = req_reg[8*j +: 8];
        sel_wdata = req_wdata[8*j +: 8];
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    win_d         = win_q;
    gnt_d         = gnt_q;
    rsp_valid_d   = '0;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_nack_d    = rsp_nack_q;
    rsp_timeout_d = rsp_timeout_q;
    m_valid_d     = m_valid_q;
    m_rnw_d       = m_rnw_q;
    m_dev_d       = m_dev_q;
    m_reg_d       = m_reg_q;
    m_wdata_d     = m_wdata_q;
    m_abort_d     = 1'b0;
    cnt_d         = cnt_q;

    unique case (state_q)
      S_IDLE: begin
        if (en && found) begin
          gnt_d       = '0;
          gnt_d[pick] = 1'b1;
          win_d       = pick;
          m_rnw_d     = sel_rnw;
          m_dev_d     = sel_dev;
          m_reg_d     = sel_reg;
          m_wdata_d   = sel_wdata;
          m_valid_d   = 1'b1;
          state_d     = S_ISSUE;
        end
      end

      S_ISSUE: begin
        if (m_ready) begin
          m_valid_d = 1'b0;
          cnt_d     = '0;
          state_d   = S_WAIT;
        end
      end

      S_WAIT: begin
        if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
        if (m_done) begin
          rsp_rdata_d        = m_rdata;
          rsp_nack_d         = m_nack;
          rsp_timeout_d      = 1'b0;
          rsp_valid_d[win_q] = 1'b1;
          state_d            = S_RESP;
        end else if (cnt_q >= CW'(TIMEOUT - 2)) begin
          // Decided one cycle early so the registered abort pulse lands
          // exactly TIMEOUT cycles after the handshake; rsp_valid follows
          // on the next cycle from within RESP.
          m_abort_d     = 1'b1;
          rsp_rdata_d   = '0;
          rsp_nack_d    = 1'b0;
          rsp_timeout_d = 1'b1;
          state_d       = S_RESP;
        end
      end

      S_RESP: begin
        if (rsp_valid_q == '0) begin
          // Timeout entry: abort cycle first, completion pulse next.
          rsp_valid_d[win_q] = 1'b1;
        end else begin
          gnt_d   = '0;
          ptr_d   = (win_q == IW'(NREQ - 1)) ? '0 : win_q + 1'b1;
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      ptr_q         <= '0;
      win_q         <= '0;
      gnt_q         <= '0;
      rsp_valid_q   <= '0;
      rsp_rdata_q   <= '0;
      rsp_nack_q    <= 1'b0;
      rsp_timeout_q <= 1'b0;
      m_valid_q     <= 1'b0;
      m_rnw_q       <= 1'b0;
      m_dev_q       <= '0;
      m_reg_q       <= '0;
      m_wdata_q     <= '0;
      m_abort_q     <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      win_q         <= win_d;
      gnt_q         <= gnt_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_nack_q    <= rsp_nack_d;
      rsp_timeout_q <= rsp_timeout_d;
      m_valid_q     <= m_valid_d;
      m_rnw_q       <= m_rnw_d;
      m_dev_q       <= m_dev_d;
      m_reg_q       <= m_reg_d;
      m_wdata_q     <= m_wdata_d;
      m_abort_q     <= m_abort_d;
      cnt_q         <= cnt_d;
    end
  end

  assign gnt         = gnt_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_nack    = rsp_nack_q;
  assign rsp_timeout = rsp_timeout_q;
  assign m_valid     = m_valid_q;
  assign m_rnw       = m_rnw_q;
  assign m_dev       = m_dev_q;
  assign m_reg       = m_reg_q;
  assign m_wdata     = m_wdata_q;
  assign m_abort     = m_abort_q;

endmodule

// File: doc/iic_cmd_arb.md
# iic_cmd_arb

Transaction-level arbiter that shares one byte-oriented IIC master command port between several requesters, such as MS72xx power-up init and runtime HDMI status polling. It sits between the requesters and the single IIC master that drives the MS72xx SCL/SDA pins. It grants one register transaction at a time in round-robin order, latches the winning command, and routes the completion back. A watchdog ends any transaction the master never completes.

## Interface
- NREQ, 2: number of requesters, 2..4.
- TIMEOUT, 200_000: cycles allowed in WAIT before abort (20 ms at 10 MHz).
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  arbitration enable. Held low until the MS72xx reset hold is released.
- req  in  NREQ  per-requester transaction request.
- req_rnw  in  NREQ  1 = register read, 0 = write.
- req_dev  in  8*NREQ  device address per requester, slice i = [8i+7:8i].
- req_reg  in  8*NREQ  register address per requester.
- req_wdata  in  8*NREQ  write data per requester.
- gnt  out  NREQ  one-hot grant, held for the whole transaction.
- rsp_valid  out  NREQ  one-hot, 1-cycle completion pulse to the granted requester.
- rsp_rdata  out  8  read data, valid with rsp_valid.
- rsp_nack  out  1  master reported NACK, valid with rsp_valid.
- rsp_timeout  out  1  transaction aborted by watchdog, valid with rsp_valid.
- m_valid  out  1  command valid to master.
- m_ready  in  1  master accepts command.
- m_rnw, m_dev, m_reg, m_wdata  out  1/8/8/8  latched command.
- m_done  in  1  master finished, 1-cycle pulse.
- m_rdata  in  8  read data, valid with m_done.
- m_nack  in  1  NACK flag, valid with m_done.
- m_abort  out  1  1-cycle pulse: master must drop the transfer and release the bus.

## Operation
- States:
  - IDLE: evaluate requests.
  - ISSUE: present command to master.
  - WAIT: transaction in flight.
  - RESP: return result to requester.
- IDLE:
  - If en=1 and any req bit is set, pick the first set bit at or after pointer ptr, wrapping modulo NREQ.
  - Set gnt to the winner and latch its req_rnw/dev/reg/wdata into m_*. Go to ISSUE.
  - If en=0, stay in IDLE; req is ignored.
- ISSUE: m_valid=1 until the cycle m_valid&m_ready, then go to WAIT and clear the watchdog counter.
- WAIT:
  - Counter increments each cycle; width $clog2(TIMEOUT+1), saturating.
  - On m_done: capture m_rdata and m_nack, set rsp_timeout=0, go to RESP.
  - If the counter reaches TIMEOUT-1 without m_done: pulse m_abort, set rsp_timeout=1, rsp_nack=0, rsp_rdata=0, go to RESP.
- RESP:
  - rsp_valid[winner]=1 for exactly one cycle, with the other rsp_* fields valid.
  - Set ptr = (winner+1) mod NREQ, clear gnt, go to IDLE.
- m_* command fields stay frozen from grant until the end of RESP. Requester inputs may change freely after gnt.
- Requester dropping req while granted: ignored. The transaction completes and rsp_valid still pulses.
- en falling mid-transaction: the current transaction completes; no new grant is issued.
- m_done outside WAIT: ignored. This includes m_done in the same cycle as the m_ready handshake.
- m_done in the same cycle the timeout fires: m_done wins; no m_abort.
- Reset at any point:
  - State goes to IDLE and ptr to 0.
  - All outputs (gnt, rsp_*, m_valid, m_*, m_abort) are 0.
  - The master is reset by its own reset; the arbiter issues no abort on reset.

## Timing
- Grant latency: req seen in IDLE at cycle t gives gnt and m_valid at t+1.
- Command handshake at cycle k gives WAIT from k+1; m_valid is low at k+1.
- m_done at cycle d gives rsp_valid at d+1 (RESP) and gnt low at d+2.
- Timeout: handshake at k gives m_abort and the state change to RESP at k+TIMEOUT, rsp_valid at k+TIMEOUT+1.
- Back-to-back: earliest next grant is 2 cycles after rsp_valid (IDLE samples, then grant).
- Overhead per transaction beyond master latency: 3 cycles.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- Single write:
  - Stimulus: req=01, dev=0xB2, reg=0x10, wdata=0x55, m_ready immediate, m_done 40 cycles later with m_nack=0.
  - Response: gnt=01 at t+1; m_* = B2/10/55; rsp_valid=01 at handshake+41 with nack=0 and timeout=0.
- Round robin:
  - Stimulus: req=11 held continuously.
  - Response: grants alternate 01, 10, 01, 10. Each next grant comes exactly 2 cycles after the previous rsp_valid.
- Read with NACK:
  - Stimulus: req=10 read; master returns m_rdata=0xA5, m_nack=1.
  - Response: rsp_valid=10, rsp_rdata=0xA5, rsp_nack=1.
- Timeout:
  - Stimulus: TIMEOUT=100; m_done never asserted.
  - Response: m_abort 1-cycle pulse at handshake+100; rsp_timeout=1 on the next cycle; then IDLE.
- Gating and reset:
  - Stimulus: en=0 with req=01.
  - Response: no grant for 1000 cycles; grant 1 cycle after en rises.
  - Stimulus: rst=1 during WAIT.
  - Response: all outputs 0 the cycle after; with req=10 pending, the next grant after reset follows ptr=0 order.
